// File: rtl/interp_fir_if.sv
// Sample-stream and coefficient-write bundle for interp_fir.
// master = upstream/control side, slave = the filter.
interface interp_fir_if #(
    parameter int unsigned G_DWIDTH   = 24,
    parameter int unsigned G_CWIDTH   = 18,
    parameter int unsigned G_NUM_TAPS = 32
) ();
    localparam int unsigned AddrW = $clog2(G_NUM_TAPS);

    logic                       coef_wr_en;
    logic [AddrW-1:0]           coef_wr_addr;
    logic signed [G_CWIDTH-1:0] coef_wr_data;
    logic signed [G_DWIDTH-1:0] din;
    logic                       din_valid;
    logic                       din_ready;
    logic signed [G_DWIDTH-1:0] dout;
    logic                       dout_valid;
    logic                       dout_ready;

    modport master (
        output coef_wr_en, coef_wr_addr, coef_wr_data, din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid
    );

    modport slave (
        input  coef_wr_en, coef_wr_addr, coef_wr_data, din, din_valid, dout_ready,
        output din_ready, dout, dout_valid
    );
endinterface

// File: rtl/interp_fir.sv
// Time-multiplexed single-multiplier FIR for the interpolator image-reject stage.
// Define INTERP_FIR_SATURATE_EN to clip the output; otherwise the output wraps.
module interp_fir #(
    parameter int unsigned G_DWIDTH     = 24,
    parameter int unsigned G_CWIDTH     = 18,
    parameter int unsigned G_NUM_TAPS   = 32,
    parameter int unsigned G_GAIN_SHIFT = 17
) (
    input logic          clk,
    input logic          reset_n,
    input logic          enable,
    interp_fir_if.slave  io_bus
);
    localparam int unsigned KW   = $clog2(G_NUM_TAPS);
    localparam int unsigned PW   = G_DWIDTH + G_CWIDTH;
    localparam int unsigned AccW = PW + KW;
    localparam logic [KW-1:0] KLast = KW'(G_NUM_TAPS - 1);

    typedef enum logic [1:0] {SmIdle, SmMac, SmOut} state_e;

    state_e                     r_state;
    state_e                     w_state_next;
    logic signed [G_DWIDTH-1:0] r_delay [G_NUM_TAPS];
    logic signed [G_CWIDTH-1:0] r_coef  [G_NUM_TAPS];
    logic signed [AccW-1:0]     r_acc;
    logic [KW-1:0]              r_k;
    logic signed [G_DWIDTH-1:0] r_dout;

    logic                       w_accept;
    logic                       w_mac_last;
    logic                       w_coef_we;
    logic signed [PW-1:0]       w_prod;
    logic signed [AccW-1:0]     w_acc_sum;
    logic signed [AccW-1:0]     w_shifted;
    logic signed [G_DWIDTH-1:0] w_dout_next;

    assign w_accept   = (r_state == SmIdle) && enable && io_bus.din_valid;
    assign w_mac_last = (r_state == SmMac) && (r_k == KLast);
    assign w_coef_we  = enable && io_bus.coef_wr_en &&
                        (32'(io_bus.coef_wr_addr) < G_NUM_TAPS);

    assign w_prod    = PW'(r_delay[r_k]) * PW'(r_coef[r_k]);
    assign w_acc_sum = r_acc + AccW'(w_prod);
    assign w_shifted = w_acc_sum >>> G_GAIN_SHIFT;

`ifdef INTERP_FIR_SATURATE_EN
    localparam logic signed [AccW-1:0] SatMax =
        {{(AccW - G_DWIDTH + 1){1'b0}}, {(G_DWIDTH - 1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin =
        {{(AccW - G_DWIDTH + 1){1'b1}}, {(G_DWIDTH - 1){1'b0}}};

    always_comb begin
        if (w_shifted > SatMax) begin
            w_dout_next = G_DWIDTH'(SatMax);
        end else if (w_shifted < SatMin) begin
            w_dout_next = G_DWIDTH'(SatMin);
        end else begin
            w_dout_next = G_DWIDTH'(w_shifted);
        end
    end
`else
    assign w_dout_next = G_DWIDTH'(w_shifted);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SmIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = SmIdle;
        end else begin
            unique case (r_state)
                SmIdle:  if (io_bus.din_valid) w_state_next = SmMac;
                SmMac:   if (r_k == KLast) w_state_next = SmOut;
                SmOut:   if (io_bus.dout_ready) w_state_next = SmIdle;
                default: w_state_next = SmIdle;
            endcase
        end
    end

    // reset_n gates din_ready so it is low for the whole time reset is asserted.
    always_comb begin
        io_bus.din_ready  = 1'b0;
        io_bus.dout_valid = 1'b0;
        unique case (r_state)
            SmIdle:  io_bus.din_ready = enable && reset_n;
            SmOut:   io_bus.dout_valid = enable;
            default: ;
        endcase
    end

    assign io_bus.dout = r_dout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < G_NUM_TAPS; i++) begin
                r_delay[i] <= '0;
                r_coef[i]  <= '0;
            end
            r_acc  <= '0;
            r_k    <= '0;
            r_dout <= '0;
        end else if (!enable) begin
            for (int i = 0; i < G_NUM_TAPS; i++) begin
                r_delay[i] <= '0;
            end
            r_acc  <= '0;
            r_k    <= '0;
            r_dout <= '0;
        end else begin
            // A MAC reading the tap being written this edge still sees the old value.
            if (w_coef_we) begin
                r_coef[io_bus.coef_wr_addr] <= io_bus.coef_wr_data;
            end
            if (w_accept) begin
                for (int i = G_NUM_TAPS - 1; i > 0; i--) begin
                    r_delay[i] <= r_delay[i-1];
                end
                r_delay[0] <= io_bus.din;
                r_acc      <= '0;
                r_k        <= '0;
            end else if (r_state == SmMac) begin
                r_acc <= w_acc_sum;
                r_k   <= r_k + 1'b1;
                if (w_mac_last) begin
                    r_dout <= w_dout_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_interp_fir.sv
// Self-checking bench for interp_fir against an arithmetic convolution model.
// Uses six taps so that out-of-range coefficient addresses are representable.
module tb_interp_fir;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 12;
    localparam int unsigned N  = 6;
    localparam int unsigned SH = 0;
    localparam int unsigned AW = $clog2(N);

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    longint m_coef [N];
    longint m_hist [N];

    always #5 clk = ~clk;

    interp_fir_if #(.G_DWIDTH(DW), .G_CWIDTH(CW), .G_NUM_TAPS(N)) io_bus ();

    interp_fir #(
        .G_DWIDTH    (DW),
        .G_CWIDTH    (CW),
        .G_NUM_TAPS  (N),
        .G_GAIN_SHIFT(SH)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable),
        .io_bus (io_bus)
    );

    function automatic logic [DW-1:0] model_out();
        longint acc = 0;
        longint hi  = (longint'(1) <<< (DW - 1)) - 1;
        longint lo  = -(longint'(1) <<< (DW - 1));
        for (int k = 0; k < N; k++) acc += m_hist[k] * m_coef[k];
        acc = acc >>> SH;
`ifdef INTERP_FIR_SATURATE_EN
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
`else
        if (hi < lo) acc = 0;
`endif
        return acc[DW-1:0];
    endfunction

    function automatic void model_push(input longint v);
        for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = v;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < N; i++) m_hist[i] = 0;
    endfunction

    task automatic write_coef(input int addr, input longint data);
        @(negedge clk);
        io_bus.coef_wr_en   = 1'b1;
        io_bus.coef_wr_addr = AW'(addr);
        io_bus.coef_wr_data = CW'(data);
        @(negedge clk);
        io_bus.coef_wr_en = 1'b0;
        if (addr < N) m_coef[addr] = data;
    endtask

    task automatic flush();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        model_flush();
    endtask

    // Bounded waits: on timeout got stays X so the caller's comparison fails.
    task automatic send_sample(input longint v, input int ready_delay, output logic [DW-1:0] got);
        int waited = 0;
        got = 'x;
        @(negedge clk);
        while (io_bus.din_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        io_bus.din       = DW'(v);
        io_bus.din_valid = 1'b1;
        @(negedge clk);
        io_bus.din_valid = 1'b0;
        waited = 0;
        while (io_bus.dout_valid !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        repeat (ready_delay) @(negedge clk);
        if (io_bus.dout_valid === 1'b1) got = io_bus.dout;
        io_bus.dout_ready = 1'b1;
        @(negedge clk);
        io_bus.dout_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_checks++;
        if (io_bus.din_ready !== 1'b0) $display("FAIL reset_din_ready: got %b want 0", io_bus.din_ready);
        else n_pass++;
        n_checks++;
        if (io_bus.dout_valid !== 1'b0) $display("FAIL reset_dout_valid: got %b want 0", io_bus.dout_valid);
        else n_pass++;
        n_checks++;
        if (io_bus.dout !== '0) $display("FAIL reset_dout: got %0h want 0", io_bus.dout);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (io_bus.din_ready !== 1'b1) $display("FAIL release_din_ready: got %b want 1", io_bus.din_ready);
        else n_pass++;
    endtask

    task automatic test_impulse();
        logic [DW-1:0] got, exp;
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        flush();
        for (int i = 0; i < N; i++) begin
            model_push(i == 0 ? 1 : 0);
            exp = model_out();
            send_sample(i == 0 ? 1 : 0, 0, got);
            n_checks++;
            if (got !== exp) $display("FAIL impulse[%0d]: got %0d want %0d", i, $signed(got), $signed(exp));
            else n_pass++;
        end
    endtask

    task automatic test_zero_stuffed_dc();
        logic [DW-1:0] got, exp;
        for (int k = 0; k < N; k++) write_coef(k, 1);
        flush();
        for (int i = 0; i < 4 * N; i++) begin
            model_push((i % 3) == 0 ? 100 : 0);
            exp = model_out();
            send_sample((i % 3) == 0 ? 100 : 0, 0, got);
            n_checks++;
            if (got !== exp) $display("FAIL dc[%0d]: got %0d want %0d", i, $signed(got), $signed(exp));
            else n_pass++;
        end
    endtask

    task automatic test_latency_backpressure();
        logic [DW-1:0] held, exp;
        int bad_hold = 0;
        @(negedge clk);
        while (io_bus.din_ready !== 1'b1) @(negedge clk);
        io_bus.din       = DW'(37);
        io_bus.din_valid = 1'b1;
        model_push(37);
        exp = model_out();
        @(negedge clk);
        io_bus.din_valid = 1'b0;
        repeat (N - 1) @(negedge clk);
        n_checks++;
        if (io_bus.dout_valid !== 1'b0) $display("FAIL latency_early: got %b want 0", io_bus.dout_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (io_bus.dout_valid !== 1'b1) $display("FAIL latency_valid: got %b want 1", io_bus.dout_valid);
        else n_pass++;
        held = io_bus.dout;
        n_checks++;
        if (held !== exp) $display("FAIL latency_value: got %0d want %0d", $signed(held), $signed(exp));
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (io_bus.dout !== held || io_bus.din_ready !== 1'b0 || io_bus.dout_valid !== 1'b1)
                bad_hold++;
        end
        n_checks++;
        if (bad_hold != 0) $display("FAIL backpressure_hold: got %0d unstable cycles want 0", bad_hold);
        else n_pass++;
        io_bus.dout_ready = 1'b1;
        @(negedge clk);
        io_bus.dout_ready = 1'b0;
        n_checks++;
        if (io_bus.dout_valid !== 1'b0) $display("FAIL backpressure_release: got %b want 0", io_bus.dout_valid);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [DW-1:0] got, exp;
        for (int k = 1; k < N; k++) write_coef(k, 0);
        write_coef(0, 2047);
        flush();
        model_push(32767);
        exp = model_out();
        send_sample(32767, 0, got);
        n_checks++;
        if (got !== exp) $display("FAIL sat_pos: got %0h want %0h", got, exp);
        else n_pass++;
        write_coef(0, -2048);
        flush();
        model_push(32767);
        exp = model_out();
        send_sample(32767, 0, got);
        n_checks++;
        if (got !== exp) $display("FAIL sat_neg: got %0h want %0h", got, exp);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [DW-1:0] got, exp;
        longint v;
        for (int k = 0; k < N; k++) write_coef(k, longint'($urandom_range(0, 4095)) - 2048);
        flush();
        for (int i = 0; i < 24; i++) begin
            v = (i < 12) ? longint'($urandom_range(0, 511)) - 256
                         : longint'($urandom_range(0, 65535)) - 32768;
            model_push(v);
            exp = model_out();
            send_sample(v, int'($urandom_range(0, 3)), got);
            n_checks++;
            if (got !== exp) $display("FAIL random[%0d]: got %0d want %0d", i, $signed(got), $signed(exp));
            else n_pass++;
        end
    endtask

    task automatic test_coef_addr();
        logic [DW-1:0] got, exp;
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        write_coef(N, 100);
        write_coef(N + 1, 200);
        write_coef(2, 5);
        @(negedge clk);
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (io_bus.din_ready !== 1'b0 || io_bus.dout_valid !== 1'b0)
                $display("FAIL disabled_handshake: got rdy=%b vld=%b want 0 0",
                         io_bus.din_ready, io_bus.dout_valid);
            else n_pass++;
        end
        enable = 1'b1;
        model_flush();
        for (int i = 0; i < N; i++) begin
            model_push(i == 0 ? 1 : 0);
            exp = model_out();
            send_sample(i == 0 ? 1 : 0, 0, got);
            n_checks++;
            if (got !== exp) $display("FAIL coef_addr[%0d]: got %0d want %0d", i, $signed(got), $signed(exp));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_mac();
        logic [DW-1:0] got, exp;
        flush();
        model_push(3);
        exp = model_out();
        send_sample(3, 0, got);
        n_checks++;
        if (got !== exp) $display("FAIL pre_reset_out: got %0d want %0d", $signed(got), $signed(exp));
        else n_pass++;
        @(negedge clk);
        while (io_bus.din_ready !== 1'b1) @(negedge clk);
        io_bus.din       = DW'(9);
        io_bus.din_valid = 1'b1;
        @(negedge clk);
        io_bus.din_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (io_bus.dout_valid !== 1'b0 || io_bus.dout !== '0 || io_bus.din_ready !== 1'b0)
            $display("FAIL reset_mid_mac: got vld=%b dout=%0h rdy=%b want 0 0 0",
                     io_bus.dout_valid, io_bus.dout, io_bus.din_ready);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < N; k++) m_coef[k] = 0;
        model_flush();
        for (int i = 0; i < N; i++) begin
            model_push(i == 0 ? 1 : 0);
            exp = model_out();
            send_sample(i == 0 ? 1 : 0, 0, got);
            n_checks++;
            if (got !== exp) $display("FAIL post_reset[%0d]: got %0d want %0d", i, $signed(got), $signed(exp));
            else n_pass++;
        end
    endtask

    task automatic test_enable_mid_mac();
        logic [DW-1:0] got, exp;
        int spurious = 0;
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        @(negedge clk);
        while (io_bus.din_ready !== 1'b1) @(negedge clk);
        io_bus.din       = DW'(11);
        io_bus.din_valid = 1'b1;
        @(negedge clk);
        io_bus.din_valid = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        model_flush();
        repeat (N + 3) begin
            @(negedge clk);
            if (io_bus.dout_valid !== 1'b0) spurious++;
        end
        n_checks++;
        if (spurious != 0) $display("FAIL enable_drop_output: got %0d valid cycles want 0", spurious);
        else n_pass++;
        model_push(7);
        exp = model_out();
        send_sample(7, 0, got);
        n_checks++;
        if (got !== exp) $display("FAIL enable_drop_next: got %0d want %0d", $signed(got), $signed(exp));
        else n_pass++;
    endtask

    initial begin
        io_bus.coef_wr_en   = 1'b0;
        io_bus.coef_wr_addr = '0;
        io_bus.coef_wr_data = '0;
        io_bus.din          = '0;
        io_bus.din_valid    = 1'b0;
        io_bus.dout_ready   = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_coef[k] = 0;
            m_hist[k] = 0;
        end
        test_reset();
        test_impulse();
        test_zero_stuffed_dc();
        test_latency_backpressure();
        test_saturation();
        test_random();
        test_coef_addr();
        test_reset_mid_mac();
        test_enable_mid_mac();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
